// File: rtl/apb_master_arbiter_pkg.sv
// Shared definitions for the APB master arbiter: FSM encoding and strobe width.
package apb_master_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    // One strobe bit per byte lane: 4 lanes up to 32-bit data, 8 beyond.
    function automatic int strb_width(input int dw);
        return (dw > 32) ? 8 : 4;
    endfunction

endpackage

// File: rtl/apb_master_arbiter_rr.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IW-1:0]   gnt_idx
);

    // Walk the requesters starting at ptr and wrapping; the first hit wins.
    always_comb begin
        int   idx;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found        = 1'b1;
                gnt[idx]     = 1'b1;
                gnt_idx      = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB completer between NREQ requesters: round-robin grant,
// SETUP/ACCESS sequencing, bounded wait on APB_READY, one-cycle response.
module apb_master_arbiter
    import apb_master_arbiter_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                            APB_CLK,
    input  logic                            APB_RESET,
    input  logic [NREQ-1:0]                 req_valid,
    input  logic [NREQ-1:0]                 req_write,
    input  logic [NREQ*DATAWIDTH-1:0]       req_addr,
    input  logic [NREQ*DATAWIDTH-1:0]       req_wdata,
    output logic [NREQ-1:0]                 req_ready,
    output logic [NREQ-1:0]                 rsp_valid,
    output logic [DATAWIDTH-1:0]            rsp_rdata,
    output logic                            rsp_err,
    output logic                            APB_SEL,
    output logic                            APB_ENABLE,
    output logic                            APB_WRITE,
    output logic [DATAWIDTH-1:0]            APB_ADDR,
    output logic [DATAWIDTH-1:0]            APB_WDATA,
    output logic [strb_width(DATAWIDTH)-1:0] APB_STRB,
    output logic [2:0]                      APB_PROT,
    input  logic [DATAWIDTH-1:0]            APB_RDATA,
    input  logic                            APB_READY,
    input  logic                            APB_SLVERR
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    apb_state_e                         state;
    logic [IW-1:0]                      ptr;
    logic [NREQ-1:0]                    owner_q;
    logic                               write_q;
    logic [DATAWIDTH-1:0]               addr_q;
    logic [DATAWIDTH-1:0]               wdata_q;
    logic [CW-1:0]                      wait_cnt;
    logic                               sel_q;
    logic                               en_q;
    logic [NREQ-1:0]                    rsp_valid_q;
    logic [DATAWIDTH-1:0]               rdata_q;
    logic                               err_q;

    logic [NREQ-1:0][DATAWIDTH-1:0]     addr_v;
    logic [NREQ-1:0][DATAWIDTH-1:0]     wdata_v;
    logic [NREQ-1:0]                    gnt;
    logic [IW-1:0]                      gnt_idx;

    assign addr_v  = req_addr;
    assign wdata_v = req_wdata;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Accept is the only combinational output; it is held off while reset is asserted.
    assign req_ready  = (state == ST_IDLE && !APB_RESET) ? gnt : '0;

    assign APB_SEL    = sel_q;
    assign APB_ENABLE = en_q;
    assign APB_WRITE  = write_q;
    assign APB_ADDR   = addr_q;
    assign APB_WDATA  = wdata_q;
    assign APB_STRB   = '1;
    assign APB_PROT   = 3'b000;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign rsp_err    = err_q;

    // Transaction FSM with latched request fields and registered bus/response outputs.
    always_ff @(posedge APB_CLK) begin
        if (APB_RESET) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            owner_q     <= '0;
            write_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt    <= '0;
            sel_q       <= 1'b0;
            en_q        <= 1'b0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rsp_valid_q <= '0;
                    rdata_q     <= '0;
                    err_q       <= 1'b0;
                    if (|req_valid) begin
                        owner_q <= gnt;
                        write_q <= req_write[gnt_idx];
                        addr_q  <= addr_v[gnt_idx];
                        wdata_q <= wdata_v[gnt_idx];
                        ptr     <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
                        sel_q   <= 1'b1;
                        en_q    <= 1'b0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    en_q     <= 1'b1;
                    wait_cnt <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (APB_READY) begin
                        sel_q       <= 1'b0;
                        en_q        <= 1'b0;
                        rsp_valid_q <= owner_q;
                        rdata_q     <= (write_q || APB_SLVERR) ? '0 : APB_RDATA;
                        err_q       <= APB_SLVERR;
                        state       <= ST_RESP;
                    end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                        // Completer never answered: abort the access as an error.
                        sel_q       <= 1'b0;
                        en_q        <= 1'b0;
                        rsp_valid_q <= owner_q;
                        rdata_q     <= '0;
                        err_q       <= 1'b1;
                        state       <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    // Single response cycle doubles as the bus-idle gap.
                    rsp_valid_q <= '0;
                    rdata_q     <= '0;
                    err_q       <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: register-bank completer model, per-requester
// request queues, and a scoreboard of expected responses filled at accept time.
module tb_apb_master_arbiter;

    localparam int NREQ  = 4;
    localparam int DW    = 32;
    localparam int TO    = 16;
    localparam int NREGS = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_write = '0;
    logic [NREQ*DW-1:0]   req_addr  = '0;
    logic [NREQ*DW-1:0]   req_wdata = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic                 rsp_err;
    logic                 apb_sel, apb_en, apb_write;
    logic [DW-1:0]        apb_addr, apb_wdata;
    logic [3:0]           apb_strb;
    logic [2:0]           apb_prot;
    logic [DW-1:0]        c_rdata = '0;
    logic                 c_ready = 1'b0;
    logic                 c_err   = 1'b0;
    logic                 slverr_mode = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct { logic w; logic [31:0] a; logic [31:0] d; } req_t;
    typedef struct { int idx; logic [31:0] rd; logic err; int due; } exp_t;

    req_t        pend [NREQ][$];
    int          head [NREQ] = '{default: 0};
    exp_t        sb[$];
    int          gseq[$];
    int          gcyc[$];
    logic [31:0] mem    [NREGS] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    logic [31:0] shadow [NREGS] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    apb_master_arbiter #(.NREQ(NREQ), .DATAWIDTH(DW), .TIMEOUT(TO)) dut (
        .APB_CLK    (clk),
        .APB_RESET  (rst),
        .req_valid  (req_valid),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .APB_SEL    (apb_sel),
        .APB_ENABLE (apb_en),
        .APB_WRITE  (apb_write),
        .APB_ADDR   (apb_addr),
        .APB_WDATA  (apb_wdata),
        .APB_STRB   (apb_strb),
        .APB_PROT   (apb_prot),
        .APB_RDATA  (c_rdata),
        .APB_READY  (c_ready),
        .APB_SLVERR (c_err)
    );

    // Register-bank completer: READY registered one cycle after ENABLE,
    // out-of-range addresses never acknowledged.
    always @(posedge clk) begin
        if (apb_sel && apb_en && !c_ready && apb_addr < NREGS * 4) begin
            c_ready <= 1'b1;
            c_err   <= slverr_mode;
            c_rdata <= apb_write ? 32'h0 : mem[apb_addr[4:2]];
            if (apb_write) mem[apb_addr[4:2]] <= apb_wdata;
        end else begin
            c_ready <= 1'b0;
            c_err   <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Requester drivers: present queue heads, advance a queue on its accept pulse.
    initial begin
        logic [NREQ-1:0] rdy;
        forever begin
            @(negedge clk);
            rdy = rst ? '0 : req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (rdy[i]) head[i]++;
                if (head[i] < pend[i].size()) begin
                    req_valid[i]            = 1'b1;
                    req_write[i]            = pend[i][head[i]].w;
                    req_addr[i*DW +: DW]    = pend[i][head[i]].a;
                    req_wdata[i*DW +: DW]   = pend[i][head[i]].d;
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
    end

    // Monitor: push expectations on accept, pop and compare on response.
    initial begin
        exp_t        e;
        int          g;
        logic [31:0] a, d;
        logic        w;
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
            end else begin
                if (req_ready != '0) begin
                    chk("rdy_onehot", $countones(req_ready), 1);
                    g = 0;
                    for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
                    a = req_addr[g*DW +: DW];
                    d = req_wdata[g*DW +: DW];
                    w = req_write[g];
                    e.idx = g;
                    if (a >= NREGS * 4) begin
                        e.rd = 0; e.err = 1'b1; e.due = cyc + 2 + TO;
                    end else if (slverr_mode) begin
                        e.rd = 0; e.err = 1'b1; e.due = cyc + 4;
                    end else if (w) begin
                        shadow[a[4:2]] = d;
                        e.rd = 0; e.err = 1'b0; e.due = cyc + 4;
                    end else begin
                        e.rd = shadow[a[4:2]]; e.err = 1'b0; e.due = cyc + 4;
                    end
                    sb.push_back(e);
                    gseq.push_back(g);
                    gcyc.push_back(cyc);
                end
                if (rsp_valid != '0) begin
                    if (sb.size() == 0) begin
                        chk("rsp_unexpected", rsp_valid, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("rsp_idx",   rsp_valid, 64'(1) << e.idx);
                        chk("rsp_rdata", rsp_rdata, e.rd);
                        chk("rsp_err",   rsp_err,   e.err);
                        chk("rsp_cycle", cyc,       e.due);
                        chk("apb_strb",  apb_strb,  4'hF);
                        chk("apb_prot",  apb_prot,  3'h0);
                    end
                end else if (sb.size() > 0 && cyc > sb[0].due) begin
                    chk("rsp_missing", 0, 1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic issue(input int i, input logic w, input logic [31:0] a, input logic [31:0] d);
        req_t r;
        r.w = w; r.a = a; r.d = d;
        pend[i].push_back(r);
    endtask

    function automatic bit all_done();
        bit ok = (sb.size() == 0) && (rsp_valid == '0);
        for (int i = 0; i < NREQ; i++) if (head[i] < pend[i].size()) ok = 0;
        return ok;
    endfunction

    task automatic wait_idle(input string tag);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (all_done()) begin
                repeat (2) @(negedge clk);
                return;
            end
        end
        chk(tag, 0, 1);
    endtask

    initial begin
        int gb;
        int exp_rr [8] = '{2, 3, 0, 1, 2, 3, 0, 1};
        bit seen;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_sel",   apb_sel,   0);
        chk("rst_en",    apb_en,    0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp",   rsp_valid, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Lone read from requester 0.
        issue(0, 1'b0, 32'h8, 32'h0);
        wait_idle("idle_t1");

        // Write by requester 1, read back by requester 2.
        issue(1, 1'b1, 32'h4, 32'h12345678);
        wait_idle("idle_t2a");
        issue(2, 1'b0, 32'h4, 32'h0);
        wait_idle("idle_t2b");

        // Hung access times out, the queued request behind it completes normally.
        issue(3, 1'b0, 32'h40, 32'h0);
        issue(0, 1'b0, 32'h8, 32'h0);
        wait_idle("idle_t3");

        // Completer error on one response only.
        slverr_mode = 1'b1;
        issue(1, 1'b0, 32'h8, 32'h0);
        wait_idle("idle_t4a");
        slverr_mode = 1'b0;
        issue(1, 1'b0, 32'h4, 32'h0);
        wait_idle("idle_t4b");

        // All four continuously requesting: rotation from ptr = 2.
        gb = gseq.size();
        for (int i = 0; i < NREQ; i++) issue(i, 1'b1, 32'(16 + 4 * i), 32'(32'hA0 + i));
        for (int i = 0; i < NREQ; i++) issue(i, 1'b0, 32'(16 + 4 * i), 32'h0);
        wait_idle("idle_rr");
        chk("rr_count", gseq.size() - gb, 8);
        for (int k = 0; k < 8; k++) chk("rr_order", gseq[gb + k], exp_rr[k]);
        for (int k = 1; k < 8; k++) chk("rr_gap", gcyc[gb + k] - gcyc[gb + k - 1], 5);

        // Reset during ACCESS of a hung read.
        issue(2, 1'b0, 32'h40, 32'h0);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (apb_sel && apb_en) seen = 1;
        end
        chk("access_seen", seen, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_sel",   apb_sel,   0);
        chk("mid_en",    apb_en,    0);
        chk("mid_ready", req_ready, 0);
        chk("mid_rsp",   rsp_valid, 0);
        chk("mid_rdata", rsp_rdata, 0);
        chk("mid_err",   rsp_err,   0);
        chk("mid_addr",  apb_addr,  0);
        gb = gseq.size();
        issue(3, 1'b0, 32'h8, 32'h0);
        issue(1, 1'b0, 32'h4, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        wait_idle("idle_rst");
        chk("post_rst_count", gseq.size() - gb, 2);
        chk("post_rst_first", gseq[gb], 1);
        chk("post_rst_second", gseq[gb + 1], 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/apb_master_arbiter.md
# apb_master_arbiter

Shares one APB completer port (an `APB_Slave_Interface` register bank) between `NREQ` independent requesters. The block arbitrates round-robin, sequences each granted request through the APB SETUP/ACCESS phases, and returns read data or an error to the winner. A bounded wait on `APB_READY` aborts a hung access, for example one to an out-of-range register that the completer never acknowledges.

## Interface
- `NREQ`, 4: number of requesters, 2..8.
- `DATAWIDTH`, 32: APB data and address width.
- `TIMEOUT`, 16: maximum ACCESS cycles allowed without `APB_READY`, ≥2.
- `APB_CLK`  in  1  clock; single clock domain.
- `APB_RESET`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NREQ  request pending; held until accepted.
- `req_write`  in  NREQ  1 = write, 0 = read.
- `req_addr`  in  NREQ*DATAWIDTH  byte addresses, requester i in slice i.
- `req_wdata`  in  NREQ*DATAWIDTH  write data, requester i in slice i.
- `req_ready`  out  NREQ  one-hot accept pulse.
- `rsp_valid`  out  NREQ  one-hot completion pulse.
- `rsp_rdata`  out  DATAWIDTH  read data; 0 on writes and on errors.
- `rsp_err`  out  1  `APB_SLVERR` or timeout.
- `APB_SEL`, `APB_ENABLE`, `APB_WRITE`  out  1  APB requester controls.
- `APB_ADDR`, `APB_WDATA`  out  DATAWIDTH  latched address and data.
- `APB_STRB`  out  4 or 8  all ones (8 when `DATAWIDTH` > 32).
- `APB_PROT`  out  3  constant 0.
- `APB_RDATA`  in  DATAWIDTH;  `APB_READY`, `APB_SLVERR`  in  1.

## Operation
- FSM states: IDLE → SETUP → ACCESS → RESP → IDLE.
- **IDLE**
  - `APB_SEL` = `APB_ENABLE` = 0.
  - If any `req_valid` is set, pick winner g by round-robin starting at `ptr`.
  - Assert `req_ready[g]` combinationally in this cycle.
  - Latch addr, wdata, write and g.
  - Set `ptr` = (g+1) mod NREQ.
  - Go to SETUP.
- **SETUP**: `APB_SEL` = 1, `APB_ENABLE` = 0, address, data and write driven from the latches. Go to ACCESS unconditionally.
- **ACCESS**
  - `APB_SEL` = `APB_ENABLE` = 1; the wait counter increments each cycle.
  - On `APB_READY`: capture `APB_RDATA` (reads only) and `APB_SLVERR`, then go to RESP.
  - If the counter reaches `TIMEOUT` without `APB_READY`: set err = 1, rdata = 0, go to RESP.
- **RESP**
  - `APB_SEL` = 0.
  - `rsp_valid[g]` = 1 for exactly this cycle, with `rsp_rdata` and `rsp_err` valid.
  - Go to IDLE.
- RESP guarantees at least one bus-idle cycle, which lets the completer return from its post-READY state before the next SETUP.
- Requester rules:
  - A requester must not drop `req_valid` before `req_ready`; doing so is undefined.
  - It may raise a new request in the same cycle as its `rsp_valid`. That request is arbitrated in the following IDLE cycle.
- Simultaneous requests: a lone requester wins every IDLE. With contention, the winner is the lowest index at or after `ptr`.
- Reset mid-transaction:
  - State returns to IDLE and `ptr` = 0.
  - All outputs go to 0, including `APB_SEL`, `APB_ENABLE`, `req_ready`, `rsp_valid`, `rsp_rdata` and `rsp_err`.
  - No response is issued for the aborted transaction.
- `APB_READY` is ignored outside ACCESS.

## Timing
- Accept at cycle T, SETUP at T+1, first ACCESS at T+2.
- `APB_READY` seen at T+1+k (k ≥ 1) gives `rsp_valid` at T+2+k.
- Zero-wait completer: `rsp_valid` at T+3.
- Register-bank completer without added delay (READY registered after ENABLE): `rsp_valid` at T+4, 5-cycle transaction period.
- Timeout: if `APB_READY` never comes, `rsp_valid` with `rsp_err` = 1 arrives at T+2+`TIMEOUT`.
- The APB outputs are decoded from registered state and latches only, so they are glitch-free.

## Structure
- The state encodings and the STRB-width function go in the shared header `apb_arb_defs.v`, next to the existing base functions.
- Sub-module `rr_arbiter`:
  - Purely combinational.
  - Inputs: `req[NREQ]`, `ptr`.
  - Outputs: one-hot `gnt`, encoded index.
- The top level holds the FSM, latches, wait counter and `ptr`.

## Test plan
- Single read, requester 0, address 0x8, bank reg 2 = 0xDEADBEEF → `req_ready[0]` at T, `rsp_valid[0]` at T+4, `rsp_rdata` = 0xDEADBEEF, `rsp_err` = 0.
- Requester 1 writes 0x12345678 to 0x4, then requester 2 reads 0x4 → second response returns 0x12345678; `APB_STRB` = 0xF and `APB_PROT` = 0 throughout.
- All four requesters held valid continuously → grants 0,1,2,3,0,…; each grant 5 cycles apart; no requester is skipped.
- Read at an address beyond the bank's register count (never acknowledged), `TIMEOUT` = 16 → `rsp_valid` at T+18 with `rsp_err` = 1 and `rsp_rdata` = 0; the next request completes normally.
- `APB_RESET` asserted during ACCESS → next cycle state is IDLE, all outputs 0, no `rsp_valid`; after release, a pending request is granted starting from requester 0.
- Completer forces `APB_SLVERR` = 1 with `APB_READY` → `rsp_err` = 1 for that response only.
